checker_scoreboard: RTL and testbench
=====================================

Name: checker_scoreboard

Overview:
- Sits directly downstream of the per-stage structural-vs-behavioral checkers in the PCIe physical-layer testbenches.
- Collects their per-cycle mismatch flags over a fixed window of valid samples and accumulates error statistics.
- Issues a single registered pass/fail verdict that the tester reads at end of test.
- Replaces ad-hoc $display scanning with a synthesizable, cycle-accurate result stage.

Parameters:
- NUM_CHK, 4, number of upstream checker mismatch flags aggregated.
- CNT_W, 16, width of the error and sample counters.
- WINDOW, 256, number of valid samples per test run (1 .. 2^CNT_W-1).

Ports:
- clk  input  1  sampling clock, shared with the upstream checkers.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a new run.
- valid  input  1  mismatch inputs are meaningful this cycle.
- mismatch  input  NUM_CHK  per-checker mismatch flag (1 = structural != behavioral).
- busy  output  1  run in progress.
- done  output  1  run finished; verdict outputs are stable.
- pass  output  1  done and zero errors.
- fail  output  1  done and at least one error.
- err_count  output  CNT_W  number of valid cycles with any mismatch; saturating.
- err_mask  output  NUM_CHK  sticky OR of mismatch over valid cycles of the run.
- first_err_idx  output  CNT_W  sample index (0-based) of the first erroneous valid cycle.
- first_err_chk  output  NUM_CHK  mismatch vector captured at the first error.

Behaviour:
- **Reset:** reset=1 at a clk edge puts the FSM in IDLE and clears every output and internal counter to 0. Reset has priority over all other inputs, including mid-run.
- **FSM states:**
  - IDLE: busy=0, done=0. start=1 -> RUN, clearing the sample counter, err_count, err_mask, first_err_idx, first_err_chk and the first-error-seen flag.
  - RUN: busy=1. Each cycle with valid=1:
    - The sample counter increments.
    - If |mismatch: err_count += 1, saturating at 2^CNT_W-1.
    - err_mask |= mismatch on every valid cycle.
    - The first time a valid cycle has |mismatch, first_err_idx gets the current sample index and first_err_chk gets mismatch. Both then hold for the rest of the run.
  - RUN, valid=0 cycles: ignored; nothing changes.
  - RUN, start: ignored (no restart mid-run).
  - RUN -> DONE transition: on the clock edge that consumes the WINDOW-th valid sample. busy drops and done rises on that same edge.
  - DONE: done=1. pass = (err_count==0); fail = ~pass. Exactly one of pass/fail is 1 while done=1. Statistics hold. start=1 -> RUN with the same clearing as from IDLE; done/pass/fail drop the next cycle.
- **Output timing:** all outputs are registered. The verdict is visible in the cycle after the last valid sample is accepted. err_count/err_mask reflect a sample in the cycle after it is accepted.
- **Boundaries:**
  - A mismatch on the final window sample is counted and included in the verdict.
  - Once err_count saturates it stays saturated; fail remains 1.
  - In IDLE, mismatch and valid do not alter any output.
  - WINDOW=1: a run completes on the first valid sample.
  - first_err_idx/first_err_chk read 0 when no error occurred; qualify them with fail.

Decomposition:
- Shared package pcie_tb_pkg:
  - FSM state typedef and encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - Saturation constant CNT_MAX = {CNT_W{1'b1}}.
- Sub-module sat_counter (CNT_W, clear, inc, value): a saturating counter used for err_count. The sample counter is a plain counter in the top level.

Test Plan:
- **Clean run:** reset, start, WINDOW=256 valid cycles with mismatch=0 -> done=1, pass=1, fail=0, err_count=0, err_mask=0 the cycle after the 256th sample.
- **Single error:** mismatch=4'b0100 on valid sample index 37 only -> fail=1, err_count=1, err_mask=4'b0100, first_err_idx=37, first_err_chk=4'b0100.
- **Gapped valid / final-sample error:** valid toggling 1/0 with mismatch=4'b0001 on the 256th valid sample -> done exactly one cycle after it, err_count=1, first_err_idx=255. Invalid cycles carrying mismatch=4'b1111 contribute nothing.
- **Saturation:** CNT_W=4, WINDOW=15, mismatch=4'b0011 on every valid cycle -> err_count=15, holds at 15, fail=1, err_mask=4'b0011.
- **Mid-run events:** a start pulse at sample 10 is ignored (run still ends after 256 samples). A second run with reset=1 asserted at sample 100 -> next cycle busy=0, all outputs 0, FSM IDLE. A following start completes a normal clean run.
- **Back-to-back runs:** in DONE with fail=1, a new start clears the statistics, and a clean second run ends with pass=1 and first_err_idx=0.

Source files
------------

// File: rtl/pcie_tb_pkg.sv
// Shared types and constants for the physical-layer checker result stage.
package pcie_tb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned DEF_CNT_W = 16;
    localparam logic [DEF_CNT_W-1:0] CNT_MAX = {DEF_CNT_W{1'b1}};

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value; used for the error tally.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] value
);

    localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            value <= '0;
        end else if (inc && (value != MAX)) begin
            value <= value + CNT_W'(1);
        end
    end

endmodule

// File: rtl/checker_scoreboard.sv
// Aggregates upstream mismatch flags over a window of valid samples and
// produces a registered pass/fail verdict with first-error capture.
module checker_scoreboard
    import pcie_tb_pkg::*;
#(
    parameter int unsigned NUM_CHK = 4,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned WINDOW  = 256
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               valid,
    input  logic [NUM_CHK-1:0] mismatch,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic               fail,
    output logic [CNT_W-1:0]   err_count,
    output logic [NUM_CHK-1:0] err_mask,
    output logic [CNT_W-1:0]   first_err_idx,
    output logic [NUM_CHK-1:0] first_err_chk
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WINDOW - 1);

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   sample_idx;
    logic [CNT_W-1:0]   sample_idx_nxt;
    logic               seen;
    logic               seen_nxt;
    logic [NUM_CHK-1:0] err_mask_nxt;
    logic [CNT_W-1:0]   first_err_idx_nxt;
    logic [NUM_CHK-1:0] first_err_chk_nxt;
    logic               clear;
    logic               inc;

    // Next-state and next-statistics logic
    always_comb begin
        state_nxt         = state;
        sample_idx_nxt    = sample_idx;
        seen_nxt          = seen;
        err_mask_nxt      = err_mask;
        first_err_idx_nxt = first_err_idx;
        first_err_chk_nxt = first_err_chk;
        clear             = 1'b0;
        inc               = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt         = RUN;
                    clear             = 1'b1;
                    sample_idx_nxt    = '0;
                    seen_nxt          = 1'b0;
                    err_mask_nxt      = '0;
                    first_err_idx_nxt = '0;
                    first_err_chk_nxt = '0;
                end
            end
            RUN: begin
                if (valid) begin
                    sample_idx_nxt = sample_idx + CNT_W'(1);
                    err_mask_nxt   = err_mask | mismatch;
                    if (|mismatch) begin
                        inc = 1'b1;
                        if (!seen) begin
                            seen_nxt          = 1'b1;
                            first_err_idx_nxt = sample_idx;
                            first_err_chk_nxt = mismatch;
                        end
                    end
                    if (sample_idx == LAST_IDX) begin
                        state_nxt = DONE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Verdict flags are decoded from the next state so they change on the same edge as the FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            sample_idx    <= '0;
            seen          <= 1'b0;
            err_mask      <= '0;
            first_err_idx <= '0;
            first_err_chk <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            fail          <= 1'b0;
        end else begin
            state         <= state_nxt;
            sample_idx    <= sample_idx_nxt;
            seen          <= seen_nxt;
            err_mask      <= err_mask_nxt;
            first_err_idx <= first_err_idx_nxt;
            first_err_chk <= first_err_chk_nxt;
            busy          <= (state_nxt == RUN);
            done          <= (state_nxt == DONE);
            pass          <= (state_nxt == DONE) && !seen_nxt;
            fail          <= (state_nxt == DONE) && seen_nxt;
        end
    end

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_err_cnt (
        .clk  (clk),
        .reset(reset),
        .clear(clear),
        .inc  (inc),
        .value(err_count)
    );

endmodule

// File: tb/tb_checker_scoreboard.sv
// Scoreboard bench: stimulus queues expected verdicts, monitors compare on done.
module tb_checker_scoreboard;

    typedef struct {
        bit          pass;
        bit          fail;
        logic [15:0] cnt;
        logic [3:0]  mask;
        logic [15:0] idx;
        logic [3:0]  chk;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, start, valid;
    logic [3:0]  mismatch;
    logic        busy, done, pass, fail;
    logic [15:0] err_count, first_err_idx;
    logic [3:0]  err_mask, first_err_chk;

    logic        reset2, start2, valid2;
    logic [3:0]  mismatch2;
    logic        busy2, done2, pass2, fail2;
    logic [3:0]  err_count2, first_err_idx2;
    logic [3:0]  err_mask2, first_err_chk2;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    exp_t q1[$];
    exp_t q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    checker_scoreboard #(.NUM_CHK(4), .CNT_W(16), .WINDOW(256)) dut (
        .clk(clk), .reset(reset), .start(start), .valid(valid), .mismatch(mismatch),
        .busy(busy), .done(done), .pass(pass), .fail(fail), .err_count(err_count),
        .err_mask(err_mask), .first_err_idx(first_err_idx), .first_err_chk(first_err_chk)
    );

    checker_scoreboard #(.NUM_CHK(4), .CNT_W(4), .WINDOW(15)) dut_sat (
        .clk(clk), .reset(reset2), .start(start2), .valid(valid2), .mismatch(mismatch2),
        .busy(busy2), .done(done2), .pass(pass2), .fail(fail2), .err_count(err_count2),
        .err_mask(err_mask2), .first_err_idx(first_err_idx2), .first_err_chk(first_err_chk2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor for the main instance: compare on each rising done
    initial begin : mon1
        logic done_prev;
        exp_t e;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (done && !done_prev) begin
                if (q1.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = q1.pop_front();
                    chk("done_cycle", cyc, e.cyc);
                    chk("pass", 32'(pass), 32'(e.pass));
                    chk("fail", 32'(fail), 32'(e.fail));
                    chk("busy_low", 32'(busy), 32'd0);
                    chk("err_count", 32'(err_count), 32'(e.cnt));
                    chk("err_mask", 32'(err_mask), 32'(e.mask));
                    chk("first_err_idx", 32'(first_err_idx), 32'(e.idx));
                    chk("first_err_chk", 32'(first_err_chk), 32'(e.chk));
                end
            end
            done_prev = done;
        end
    end

    // Monitor for the narrow saturating instance
    initial begin : mon2
        logic done_prev;
        exp_t e;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (done2 && !done_prev) begin
                if (q2.size() == 0) begin
                    chk("sat_unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = q2.pop_front();
                    chk("sat_done_cycle", cyc, e.cyc);
                    chk("sat_pass", 32'(pass2), 32'(e.pass));
                    chk("sat_fail", 32'(fail2), 32'(e.fail));
                    chk("sat_err_count", 32'(err_count2), 32'(e.cnt));
                    chk("sat_err_mask", 32'(err_mask2), 32'(e.mask));
                    chk("sat_first_err_idx", 32'(first_err_idx2), 32'(e.idx));
                    chk("sat_first_err_chk", 32'(first_err_chk2), 32'(e.chk));
                end
            end
            done_prev = done2;
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_pass"}, 32'(pass), 32'd0);
        chk({tag, "_fail"}, 32'(fail), 32'd0);
        chk({tag, "_err_count"}, 32'(err_count), 32'd0);
        chk({tag, "_err_mask"}, 32'(err_mask), 32'd0);
        chk({tag, "_first_idx"}, 32'(first_err_idx), 32'd0);
        chk({tag, "_first_chk"}, 32'(first_err_chk), 32'd0);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_done_drop", 32'(done), 32'd0);
        chk("start_cleared_count", 32'(err_count), 32'd0);
        chk("start_cleared_mask", 32'(err_mask), 32'd0);
    endtask

    // One full 256-sample run; err_at < 0 means a clean run
    task automatic run_main(input int err_at, input logic [3:0] err_vec,
                            input bit gapped, input int start_at);
        exp_t e;
        e.pass = (err_at < 0);
        e.fail = (err_at >= 0);
        e.cnt  = (err_at >= 0) ? 16'd1 : 16'd0;
        e.mask = (err_at >= 0) ? err_vec : 4'd0;
        e.idx  = (err_at >= 0) ? 16'(err_at) : 16'd0;
        e.chk  = (err_at >= 0) ? err_vec : 4'd0;
        do_start();
        for (int i = 0; i < 256; i++) begin
            valid    = 1'b1;
            mismatch = (i == err_at) ? err_vec : 4'd0;
            start    = (i == start_at);
            if (i == 255) begin
                e.cyc = cyc + 1;
                q1.push_back(e);
            end
            tick();
            start = 1'b0;
            if (gapped) begin
                valid    = 1'b0;
                mismatch = 4'hF;
                tick();
            end
        end
        valid    = 1'b0;
        mismatch = 4'd0;
    endtask

    task automatic drain();
        int t = 0;
        while ((q1.size() != 0 || q2.size() != 0) && t < 20) begin
            tick();
            t++;
        end
        chk("queue_drained", 32'(q1.size() + q2.size()), 32'd0);
    endtask

    initial begin
        exp_t e;
        reset = 1'b1; start = 1'b0; valid = 1'b0; mismatch = 4'd0;
        reset2 = 1'b1; start2 = 1'b0; valid2 = 1'b0; mismatch2 = 4'd0;
        tick(); tick();
        reset = 1'b0; reset2 = 1'b0;
        check_all_zero("reset");

        // IDLE ignores valid/mismatch
        valid = 1'b1; mismatch = 4'hF;
        repeat (3) tick();
        valid = 1'b0; mismatch = 4'd0;
        check_all_zero("idle");

        run_main(-1, 4'd0, 1'b0, -1);
        drain();

        run_main(37, 4'b0100, 1'b0, -1);
        drain();
        repeat (3) tick();
        chk("hold_done", 32'(done), 32'd1);
        chk("hold_fail", 32'(fail), 32'd1);
        chk("hold_err_count", 32'(err_count), 32'd1);

        // Back-to-back from a failed run, with an ignored mid-run start
        run_main(-1, 4'd0, 1'b0, 10);
        drain();

        run_main(255, 4'b0001, 1'b1, -1);
        drain();

        // Reset mid-run at sample 100
        do_start();
        for (int i = 0; i < 100; i++) begin
            valid = 1'b1;
            mismatch = (i == 5) ? 4'b1000 : 4'd0;
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        valid = 1'b0;
        mismatch = 4'd0;
        check_all_zero("midrun_reset");

        run_main(-1, 4'd0, 1'b0, -1);
        drain();

        // Saturation on the 4-bit, 15-sample instance
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        chk("sat_start_busy", 32'(busy2), 32'd1);
        e.pass = 1'b0; e.fail = 1'b1; e.cnt = 16'd15; e.mask = 4'b0011;
        e.idx = 16'd0; e.chk = 4'b0011;
        for (int i = 0; i < 15; i++) begin
            valid2 = 1'b1;
            mismatch2 = 4'b0011;
            if (i == 14) begin
                e.cyc = cyc + 1;
                q2.push_back(e);
            end
            tick();
        end
        valid2 = 1'b0;
        mismatch2 = 4'd0;
        drain();
        repeat (3) tick();
        chk("sat_hold_count", 32'(err_count2), 32'd15);
        chk("sat_hold_fail", 32'(fail2), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
